// File: rtl/serial_word_tx_if.sv
// ---------------------------------------------------------------------------
// serial_word_tx_if
//   Word-input handshake bundle for serial_word_tx.
//   in_data   word to transmit (WIDTH bits)
//   in_valid  producer has a word this cycle
//   in_ready  transmitter can accept a word; transfer = in_valid & in_ready
// Modports:
//   master  producer side (drives in_data/in_valid)
//   slave   transmitter side (drives in_ready)
// ---------------------------------------------------------------------------
interface serial_word_tx_if #(
  parameter int WIDTH = 6
) ();
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/serial_word_tx.sv
// ---------------------------------------------------------------------------
// serial_word_tx
//   Parallel-in, serial-out transmitter feeding a WIDTH-bit serial-in shift
//   register. One bit per clock, MSB first by default. A one-word holding
//   buffer lets back-to-back words stream with no idle bit between them.
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset (0 = in reset)
//   in_if       slave side of the word handshake (in_data/in_valid/in_ready)
//   abort       synchronous flush of shifter and holding buffer
//   serial_out  serial bit stream (IDLE_LEVEL when no data bit)
//   bit_valid   serial_out carries a data bit this cycle
//   last_bit    final bit of the current word
//   busy        shifter active or holding buffer full
// All outputs are registered except in_ready.
// ---------------------------------------------------------------------------
module serial_word_tx #(
  parameter int   WIDTH      = 6,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  serial_word_tx_if.slave  in_if,
  input  logic             abort,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q,      state_d;
  logic [WIDTH-1:0] shift_q,      shift_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [WIDTH-1:0] hold_q,       hold_d;
  logic             hold_full_q,  hold_full_d;
  logic             serial_out_q, serial_out_d;
  logic             bit_valid_q,  bit_valid_d;
  logic             last_bit_q,   last_bit_d;
  logic             busy_q,       busy_d;

  logic             xfer;
  logic             load;
  logic [WIDTH-1:0] load_word;

  // Bit that leaves the word first, and the word with that bit removed.
  function automatic logic head_bit(input logic [WIDTH-1:0] word);
    return MSB_FIRST ? word[WIDTH-1] : word[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] word);
    return MSB_FIRST ? (word << 1) : (word >> 1);
  endfunction

  // Abort blocks acceptance in the same cycle so a coincident word is not
  // silently flushed.
  assign in_if.in_ready = reset & ~hold_full_q & ~abort;
  assign xfer           = in_if.in_valid & in_if.in_ready;

  // shift_q holds the bits still to be sent; serial_out_q is the bit being
  // presented now and cnt_q is its index within the word.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    serial_out_d = IDLE_LEVEL;
    bit_valid_d  = 1'b0;
    load         = 1'b0;
    load_word    = '0;

    if (abort) begin
      state_d     = IDLE;
      shift_d     = '0;
      cnt_d       = '0;
      hold_d      = '0;
      hold_full_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Holding buffer is always empty here; load the shifter directly.
          if (xfer) begin
            load      = 1'b1;
            load_word = in_if.in_data;
          end
        end

        SHIFT: begin
          if (cnt_q != LAST_CNT) begin
            cnt_d        = cnt_q + 1'b1;
            serial_out_d = head_bit(shift_q);
            shift_d      = advance(shift_q);
            bit_valid_d  = 1'b1;
            // in_ready guarantees the buffer is empty when this fires.
            if (xfer) begin
              hold_d      = in_if.in_data;
              hold_full_d = 1'b1;
            end
          end else if (hold_full_q) begin
            load        = 1'b1;
            load_word   = hold_q;
            hold_d      = '0;
            hold_full_d = 1'b0;
          end else if (xfer) begin
            // Word arriving on the last bit goes straight in: no gap bit.
            load      = 1'b1;
            load_word = in_if.in_data;
          end else begin
            state_d = IDLE;
            shift_d = '0;
            cnt_d   = '0;
          end
        end

        default: state_d = IDLE;
      endcase
    end

    if (load) begin
      state_d      = SHIFT;
      cnt_d        = '0;
      serial_out_d = head_bit(load_word);
      shift_d      = advance(load_word);
      bit_valid_d  = 1'b1;
    end

    last_bit_d = bit_valid_d & (cnt_d == LAST_CNT);
    busy_d     = (state_d == SHIFT) | hold_full_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      serial_out_q <= IDLE_LEVEL;
      bit_valid_q  <= 1'b0;
      last_bit_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // computed for this edge, independent of statement order.
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      serial_out_q <= serial_out_d;
      bit_valid_q  <= bit_valid_d;
      last_bit_q   <= last_bit_d;
      busy_q       <= busy_d;
    end
  end

  assign serial_out = serial_out_q;
  assign bit_valid  = bit_valid_q;
  assign last_bit   = last_bit_q;
  assign busy       = busy_q;

endmodule
